// File: rtl/reg_read_stage_if.sv
// Bundle, writeback and exec-side signals of reg_read_stage grouped as one interface.
// slave is the stage itself; master is the decode/writeback/exec side driving it.
interface reg_read_stage_if #(
   parameter int LANES      = 2,
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 5,
   parameter int OPCODE_W   = 7,
   parameter int WB_PORTS   = 4
);
   logic                           flush_i;
   logic                           in_valid_i;
   logic                           in_ready_o;
   logic [LANES-1:0]               lane_en_i;
   logic [LANES-1:0]               pwrite_i;
   logic [LANES-1:0]               pread_i;
   logic [LANES-1:0]               sread_i;
   logic [LANES*OPCODE_W-1:0]      opcode_i;
   logic [LANES*2-1:0]             func_type_i;
   logic [LANES*REG_ADDR_W-1:0]    prim_addr_i;
   logic [LANES*DATA_W-1:0]        sec_field_i;
   logic [WB_PORTS-1:0]            wb_en_i;
   logic [WB_PORTS*REG_ADDR_W-1:0] wb_addr_i;
   logic [WB_PORTS*DATA_W-1:0]     wb_data_i;
   logic                           out_valid_o;
   logic                           out_ready_i;
   logic [LANES-1:0]               lane_en_o;
   logic [LANES-1:0]               wb_o;
   logic [LANES*OPCODE_W-1:0]      opcode_o;
   logic [LANES*2-1:0]             func_type_o;
   logic [LANES*REG_ADDR_W-1:0]    reg_addr_o;
   logic [LANES*DATA_W-1:0]        prim_op_o;
   logic [LANES*DATA_W-1:0]        sec_op_o;

   modport slave (
      input  flush_i, in_valid_i, lane_en_i, pwrite_i, pread_i, sread_i,
             opcode_i, func_type_i, prim_addr_i, sec_field_i,
             wb_en_i, wb_addr_i, wb_data_i, out_ready_i,
      output in_ready_o, out_valid_o, lane_en_o, wb_o, opcode_o,
             func_type_o, reg_addr_o, prim_op_o, sec_op_o
   );

   modport master (
      output flush_i, in_valid_i, lane_en_i, pwrite_i, pread_i, sread_i,
             opcode_i, func_type_i, prim_addr_i, sec_field_i,
             wb_en_i, wb_addr_i, wb_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, lane_en_o, wb_o, opcode_o,
             func_type_o, reg_addr_o, prim_op_o, sec_op_o
   );
endinterface

// File: rtl/reg_read_stage.sv
// Two-stage register-read pipeline with writeback forwarding and snooping of held operands.
// Optional hazard scoreboard enabled by defining RRS_SCOREBOARD_EN.
module reg_read_stage #(
   parameter int LANES      = 2,
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 5,
   parameter int OPCODE_W   = 7,
   parameter int WB_PORTS   = 4
) (
   input logic             clock_i,
   input logic             reset_i,
   reg_read_stage_if.slave bus
);
   localparam int NREG = 2 ** REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0]     data_t;

   logic [NREG-1:0][DATA_W-1:0]         r_rf;
   logic [LANES-1:0][REG_ADDR_W-1:0]    w_paddr_in;
   logic [LANES-1:0][REG_ADDR_W-1:0]    w_saddr_in;
   logic [LANES-1:0][DATA_W-1:0]        w_sfield_in;
   logic [WB_PORTS-1:0][REG_ADDR_W-1:0] w_wb_addr;
   logic [WB_PORTS-1:0][DATA_W-1:0]     w_wb_data;

   logic                             r_vld_p1, r_vld_p2;
   logic [LANES-1:0]                 r_lane_en_p1, r_pwrite_p1, r_pread_p1, r_sread_p1;
   logic [LANES-1:0]                 r_lane_en_p2, r_pwrite_p2, r_pread_p2, r_sread_p2;
   logic [LANES-1:0][OPCODE_W-1:0]   r_opc_p1, r_opc_p2;
   logic [LANES-1:0][1:0]            r_ftype_p1, r_ftype_p2;
   logic [LANES-1:0][REG_ADDR_W-1:0] r_paddr_p1, r_saddr_p1, r_paddr_p2, r_saddr_p2;
   logic [LANES-1:0][DATA_W-1:0]     r_prim_p1, r_sec_p1, r_prim_p2, r_sec_p2;

   logic [LANES-1:0][DATA_W-1:0] w_prim_in, w_sec_in;
   logic [LANES-1:0][DATA_W-1:0] w_prim_s1, w_sec_s1, w_prim_s2, w_sec_s2;
   logic                         w_advance, w_ready, w_accept;

   assign w_paddr_in  = bus.prim_addr_i;
   assign w_sfield_in = bus.sec_field_i;
   assign w_wb_addr   = bus.wb_addr_i;
   assign w_wb_data   = bus.wb_data_i;

   // Later ports overwrite earlier ones, so the highest matching port index wins.
   function automatic data_t fwd(input addr_t a, input data_t old,
                                 input logic [WB_PORTS-1:0] en,
                                 input logic [WB_PORTS-1:0][REG_ADDR_W-1:0] wa,
                                 input logic [WB_PORTS-1:0][DATA_W-1:0] wd);
      data_t v;
      v = old;
      for (int p = 0; p < WB_PORTS; p++)
         if (en[p] && wa[p] == a) v = wd[p];
      return v;
   endfunction

   always_comb begin
      w_saddr_in = '0;
      w_prim_in  = '0;
      w_sec_in   = '0;
      w_prim_s1  = '0;
      w_sec_s1   = '0;
      w_prim_s2  = '0;
      w_sec_s2   = '0;
      for (int l = 0; l < LANES; l++) begin
         w_saddr_in[l] = w_sfield_in[l][REG_ADDR_W-1:0];
         w_prim_in[l]  = bus.pread_i[l]
                       ? fwd(w_paddr_in[l], r_rf[w_paddr_in[l]], bus.wb_en_i, w_wb_addr, w_wb_data)
                       : DATA_W'(w_paddr_in[l]);
         w_sec_in[l]   = bus.sread_i[l]
                       ? fwd(w_saddr_in[l], r_rf[w_saddr_in[l]], bus.wb_en_i, w_wb_addr, w_wb_data)
                       : w_sfield_in[l];
         // Held register operands track writebacks; literals pass untouched.
         w_prim_s1[l]  = r_pread_p1[l]
                       ? fwd(r_paddr_p1[l], r_prim_p1[l], bus.wb_en_i, w_wb_addr, w_wb_data)
                       : r_prim_p1[l];
         w_sec_s1[l]   = r_sread_p1[l]
                       ? fwd(r_saddr_p1[l], r_sec_p1[l], bus.wb_en_i, w_wb_addr, w_wb_data)
                       : r_sec_p1[l];
         w_prim_s2[l]  = r_pread_p2[l]
                       ? fwd(r_paddr_p2[l], r_prim_p2[l], bus.wb_en_i, w_wb_addr, w_wb_data)
                       : r_prim_p2[l];
         w_sec_s2[l]   = r_sread_p2[l]
                       ? fwd(r_saddr_p2[l], r_sec_p2[l], bus.wb_en_i, w_wb_addr, w_wb_data)
                       : r_sec_p2[l];
      end
   end

   assign w_advance = !r_vld_p2 || bus.out_ready_i;
   assign w_accept  = bus.in_valid_i && w_ready;

`ifdef RRS_SCOREBOARD_EN
   logic [NREG-1:0] r_pend;
   logic            w_hazard;

   function automatic logic wb_hit(input addr_t a, input logic [WB_PORTS-1:0] en,
                                   input logic [WB_PORTS-1:0][REG_ADDR_W-1:0] wa);
      logic h;
      h = 1'b0;
      for (int p = 0; p < WB_PORTS; p++)
         if (en[p] && wa[p] == a) h = 1'b1;
      return h;
   endfunction

   // A writeback landing this cycle resolves the hazard; forwarding supplies its value.
   always_comb begin
      w_hazard = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         if (bus.lane_en_i[l]) begin
            if (bus.pread_i[l] && r_pend[w_paddr_in[l]] &&
                !wb_hit(w_paddr_in[l], bus.wb_en_i, w_wb_addr)) w_hazard = 1'b1;
            if (bus.sread_i[l] && r_pend[w_saddr_in[l]] &&
                !wb_hit(w_saddr_in[l], bus.wb_en_i, w_wb_addr)) w_hazard = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_pend <= '0;
      end else if (bus.flush_i) begin
         r_pend <= '0;
      end else begin
         for (int p = 0; p < WB_PORTS; p++)
            if (bus.wb_en_i[p]) r_pend[w_wb_addr[p]] <= 1'b0;
         for (int l = 0; l < LANES; l++)
            if (w_accept && bus.lane_en_i[l] && bus.pwrite_i[l]) r_pend[w_paddr_in[l]] <= 1'b1;
      end
   end

   assign w_ready = w_advance && !w_hazard;
`else
   assign w_ready = w_advance;
`endif

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_rf         <= '0;
         r_vld_p1     <= 1'b0;
         r_vld_p2     <= 1'b0;
         r_lane_en_p1 <= '0; r_pwrite_p1 <= '0; r_pread_p1 <= '0; r_sread_p1 <= '0;
         r_lane_en_p2 <= '0; r_pwrite_p2 <= '0; r_pread_p2 <= '0; r_sread_p2 <= '0;
         r_opc_p1     <= '0; r_ftype_p1  <= '0; r_paddr_p1 <= '0; r_saddr_p1 <= '0;
         r_opc_p2     <= '0; r_ftype_p2  <= '0; r_paddr_p2 <= '0; r_saddr_p2 <= '0;
         r_prim_p1    <= '0; r_sec_p1    <= '0; r_prim_p2  <= '0; r_sec_p2   <= '0;
      end else begin
         for (int p = 0; p < WB_PORTS; p++)
            if (bus.wb_en_i[p]) r_rf[w_wb_addr[p]] <= w_wb_data[p];

         if (bus.flush_i) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
         end else if (w_advance) begin
            r_vld_p1 <= w_accept;
            r_vld_p2 <= r_vld_p1;
         end

         if (w_advance) begin
            // S1 capture: read / resolve of the incoming bundle
            r_lane_en_p1 <= bus.lane_en_i;
            r_pwrite_p1  <= bus.pwrite_i;
            r_pread_p1   <= bus.pread_i;
            r_sread_p1   <= bus.sread_i;
            r_opc_p1     <= bus.opcode_i;
            r_ftype_p1   <= bus.func_type_i;
            r_paddr_p1   <= w_paddr_in;
            r_saddr_p1   <= w_saddr_in;
            r_prim_p1    <= w_prim_in;
            r_sec_p1     <= w_sec_in;
            // S2 capture: output register
            r_lane_en_p2 <= r_lane_en_p1;
            r_pwrite_p2  <= r_pwrite_p1;
            r_pread_p2   <= r_pread_p1;
            r_sread_p2   <= r_sread_p1;
            r_opc_p2     <= r_opc_p1;
            r_ftype_p2   <= r_ftype_p1;
            r_paddr_p2   <= r_paddr_p1;
            r_saddr_p2   <= r_saddr_p1;
            r_prim_p2    <= w_prim_s1;
            r_sec_p2     <= w_sec_s1;
         end else begin
            r_prim_p1 <= w_prim_s1;
            r_sec_p1  <= w_sec_s1;
            r_prim_p2 <= w_prim_s2;
            r_sec_p2  <= w_sec_s2;
         end
      end
   end

   assign bus.in_ready_o  = w_ready;
   assign bus.out_valid_o = r_vld_p2;
   assign bus.lane_en_o   = r_lane_en_p2;
   assign bus.wb_o        = r_pwrite_p2;
   assign bus.opcode_o    = r_opc_p2;
   assign bus.func_type_o = r_ftype_p2;
   assign bus.reg_addr_o  = r_paddr_p2;
   assign bus.prim_op_o   = r_prim_p2;
   assign bus.sec_op_o    = r_sec_p2;
endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model (register operands track the live RF).
module tb_reg_read_stage;
   localparam int LANES = 2, DATA_W = 16, REG_ADDR_W = 5, OPCODE_W = 7, WB_PORTS = 4;
   localparam int NREG = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   reg_read_stage_if #(.LANES(LANES), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W),
                       .OPCODE_W(OPCODE_W), .WB_PORTS(WB_PORTS)) bus ();

   reg_read_stage #(.LANES(LANES), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W),
                    .OPCODE_W(OPCODE_W), .WB_PORTS(WB_PORTS))
      dut (.clock_i(clk), .reset_i(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  lane_en, pwrite, pread, sread;
      logic [13:0] opc;
      logic [3:0]  ft;
      logic [9:0]  paddr;
      logic [31:0] sfield;
      int          acc;
   } bundle_t;

   bundle_t          q[$];
   logic [15:0]      m_rf [NREG];
   logic [NREG-1:0]  m_pend;
   int               cyc;

   task automatic m_reset();
      for (int i = 0; i < NREG; i++) m_rf[i] = 16'h0;
      m_pend = '0;
      q.delete();
      cyc = 0;
   endtask

   function automatic logic m_wb_hit(input logic [4:0] a);
      logic h = 1'b0;
      for (int p = 0; p < WB_PORTS; p++)
         if (bus.wb_en_i[p] && bus.wb_addr_i[p*5 +: 5] == a) h = 1'b1;
      return h;
   endfunction

   function automatic logic m_hazard();
      logic h = 1'b0;
`ifdef RRS_SCOREBOARD_EN
      for (int l = 0; l < LANES; l++) begin
         logic [4:0] pa, sa;
         pa = bus.prim_addr_i[l*5 +: 5];
         sa = bus.sec_field_i[l*16 +: 5];
         if (bus.lane_en_i[l] && bus.pread_i[l] && m_pend[pa] && !m_wb_hit(pa)) h = 1'b1;
         if (bus.lane_en_i[l] && bus.sread_i[l] && m_pend[sa] && !m_wb_hit(sa)) h = 1'b1;
      end
`endif
      return h;
   endfunction

   function automatic logic m_ov();
      return (q.size() > 0) && (cyc >= q[0].acc + 2);
   endfunction

   function automatic logic m_rdy();
      return (!m_ov() || bus.out_ready_i) && !m_hazard();
   endfunction

   function automatic logic [15:0] m_prim(input bundle_t b, input int l);
      logic [4:0] a;
      a = b.paddr[l*5 +: 5];
      return b.pread[l] ? m_rf[a] : {11'b0, a};
   endfunction

   function automatic logic [15:0] m_sec(input bundle_t b, input int l);
      logic [15:0] f;
      f = b.sfield[l*16 +: 16];
      return b.sread[l] ? m_rf[f[4:0]] : f;
   endfunction

   // One clock: advance the reference model with the inputs presented this cycle.
   task automatic tick();
      logic rdy, ov, acc;
      bundle_t b;
      rdy = m_rdy();
      ov  = m_ov();
      acc = bus.in_valid_i && rdy;
      b.lane_en = bus.lane_en_i; b.pwrite = bus.pwrite_i;
      b.pread = bus.pread_i; b.sread = bus.sread_i;
      b.opc = bus.opcode_i; b.ft = bus.func_type_i;
      b.paddr = bus.prim_addr_i; b.sfield = bus.sec_field_i; b.acc = cyc;
      @(posedge clk);
      if (bus.flush_i) begin
         q.delete();
         m_pend = '0;
      end else begin
         if (ov && bus.out_ready_i) void'(q.pop_front());
         if (acc) q.push_back(b);
         for (int p = 0; p < WB_PORTS; p++)
            if (bus.wb_en_i[p]) m_pend[bus.wb_addr_i[p*5 +: 5]] = 1'b0;
         for (int l = 0; l < LANES; l++)
            if (acc && b.lane_en[l] && b.pwrite[l]) m_pend[b.paddr[l*5 +: 5]] = 1'b1;
      end
      for (int p = 0; p < WB_PORTS; p++)
         if (bus.wb_en_i[p]) m_rf[bus.wb_addr_i[p*5 +: 5]] = bus.wb_data_i[p*16 +: 16];
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle();
      bus.flush_i = 0; bus.in_valid_i = 0; bus.lane_en_i = 0; bus.pwrite_i = 0;
      bus.pread_i = 0; bus.sread_i = 0; bus.opcode_i = 0; bus.func_type_i = 0;
      bus.prim_addr_i = 0; bus.sec_field_i = 0; bus.wb_en_i = 0; bus.wb_addr_i = 0;
      bus.wb_data_i = 0; bus.out_ready_i = 1;
   endtask

   task automatic test_reset();
      idle();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.lane_en_o !== 2'b00) begin errors++; $display("FAIL reset_lane_en: got %b want 00", bus.lane_en_o); end
      checks++; if (bus.prim_op_o !== 32'h0 || bus.sec_op_o !== 32'h0) begin errors++; $display("FAIL reset_ops: got %h/%h want 0/0", bus.prim_op_o, bus.sec_op_o); end
      checks++; if (bus.reg_addr_o !== 10'h0 || bus.opcode_o !== 14'h0) begin errors++; $display("FAIL reset_fields: got %h/%h want 0/0", bus.reg_addr_o, bus.opcode_o); end
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      #1;
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
   endtask

   task automatic test_basic();
      idle(); bus.wb_en_i = 4'b0001; bus.wb_addr_i[4:0] = 5'd3; bus.wb_data_i[15:0] = 16'h1234;
      tick();
      idle(); bus.in_valid_i = 1; bus.lane_en_i = 2'b01; bus.pread_i = 2'b01; bus.sread_i = 2'b01;
      bus.prim_addr_i[4:0] = 5'd3; bus.sec_field_i[15:0] = 16'd5; bus.opcode_i[6:0] = 7'h2A;
      #1;
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", bus.in_ready_o); end
      tick();
      idle(); #1;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL basic_latency1: got %b want 0", bus.out_valid_o); end
      tick(); #1;
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.out_valid_o); end
      checks++; if (bus.prim_op_o[15:0] !== 16'h1234) begin errors++; $display("FAIL basic_prim: got %h want 1234", bus.prim_op_o[15:0]); end
      checks++; if (bus.sec_op_o[15:0] !== 16'h0000) begin errors++; $display("FAIL basic_sec: got %h want 0000", bus.sec_op_o[15:0]); end
      checks++; if (bus.reg_addr_o[4:0] !== 5'd3) begin errors++; $display("FAIL basic_reg_addr: got %h want 03", bus.reg_addr_o[4:0]); end
      checks++; if (bus.lane_en_o !== 2'b01 || bus.opcode_o[6:0] !== 7'h2A) begin errors++; $display("FAIL basic_lane_opc: got %b/%h want 01/2a", bus.lane_en_o, bus.opcode_o[6:0]); end
      tick();
   endtask

   task automatic test_forward();
      idle(); bus.in_valid_i = 1; bus.lane_en_i = 2'b10; bus.pread_i = 2'b10;
      bus.prim_addr_i[9:5] = 5'd7; bus.opcode_i[13:7] = 7'h11;
      bus.wb_en_i = 4'b0110; bus.wb_addr_i[9:5] = 5'd7; bus.wb_addr_i[14:10] = 5'd7;
      bus.wb_data_i[31:16] = 16'hAAAA; bus.wb_data_i[47:32] = 16'h5555;
      tick(); idle(); tick(); #1;
      checks++; if (bus.out_valid_o !== 1'b1 || bus.lane_en_o !== 2'b10) begin errors++; $display("FAIL fwd_valid: got %b/%b want 1/10", bus.out_valid_o, bus.lane_en_o); end
      checks++; if (bus.prim_op_o[31:16] !== 16'h5555) begin errors++; $display("FAIL fwd_prim: got %h want 5555", bus.prim_op_o[31:16]); end
      checks++; if (bus.reg_addr_o[9:5] !== 5'd7) begin errors++; $display("FAIL fwd_reg_addr: got %h want 07", bus.reg_addr_o[9:5]); end
      tick();
   endtask

   task automatic test_backpressure();
      idle(); bus.in_valid_i = 1; bus.lane_en_i = 2'b01; bus.pread_i = 2'b01;
      bus.prim_addr_i[4:0] = 5'd3; bus.sec_field_i[15:0] = 16'h0042;
      tick();
      idle(); bus.out_ready_i = 0; tick();
      for (int i = 0; i < 4; i++) begin
         idle(); bus.out_ready_i = 0; bus.in_valid_i = 1; bus.lane_en_i = 2'b01;
         bus.prim_addr_i[4:0] = 5'h0A; bus.sec_field_i[15:0] = 16'h0077;
         if (i == 1) begin bus.wb_en_i = 4'b0100; bus.wb_addr_i[14:10] = 5'd3; bus.wb_data_i[47:32] = 16'hBEEF; end
         #1;
         checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.in_ready_o); end
         checks++; if (bus.out_valid_o !== 1'b1 || bus.sec_op_o[15:0] !== 16'h0042 || bus.reg_addr_o[4:0] !== 5'd3) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h/%h want 1/0042/03", i, bus.out_valid_o, bus.sec_op_o[15:0], bus.reg_addr_o[4:0]); end
         checks++; if (bus.prim_op_o[15:0] !== (i < 2 ? 16'h1234 : 16'hBEEF)) begin errors++; $display("FAIL bp_snoop[%0d]: got %h want %h", i, bus.prim_op_o[15:0], (i < 2 ? 16'h1234 : 16'hBEEF)); end
         tick();
      end
      bus.out_ready_i = 1; #1;
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", bus.in_ready_o); end
      tick();
      idle(); #1;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_gap: got %b want 0", bus.out_valid_o); end
      tick(); #1;
      checks++; if (bus.out_valid_o !== 1'b1 || bus.prim_op_o[15:0] !== 16'h000A || bus.sec_op_o[15:0] !== 16'h0077) begin errors++; $display("FAIL bp_next: got %b/%h/%h want 1/000a/0077", bus.out_valid_o, bus.prim_op_o[15:0], bus.sec_op_o[15:0]); end
      tick();
   endtask

   task automatic test_flush();
      idle(); bus.in_valid_i = 1; bus.lane_en_i = 2'b01; bus.prim_addr_i[4:0] = 5'h11;
      tick();
      idle(); bus.flush_i = 1; bus.in_valid_i = 1; bus.lane_en_i = 2'b11; bus.prim_addr_i = 10'h3FF;
      bus.wb_en_i = 4'b0010; bus.wb_addr_i[9:5] = 5'd9; bus.wb_data_i[31:16] = 16'h9999;
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d]: got %b want 0", i, bus.out_valid_o); end
         tick();
      end
      bus.in_valid_i = 1; bus.lane_en_i = 2'b01; bus.pread_i = 2'b01; bus.prim_addr_i[4:0] = 5'd9;
      tick(); idle(); tick(); #1;
      checks++; if (bus.out_valid_o !== 1'b1 || bus.prim_op_o[15:0] !== 16'h9999) begin errors++; $display("FAIL flush_after: got %b/%h want 1/9999", bus.out_valid_o, bus.prim_op_o[15:0]); end
      tick();
   endtask

   task automatic test_literal();
      idle(); bus.in_valid_i = 1; bus.lane_en_i = 2'b01; bus.prim_addr_i[4:0] = 5'h1F;
      bus.sec_field_i[15:0] = 16'hC0DE;
      bus.wb_en_i = 4'b1000; bus.wb_addr_i[19:15] = 5'h1F; bus.wb_data_i[63:48] = 16'hFFFF;
      tick();
      idle(); bus.wb_en_i = 4'b0011; bus.wb_addr_i[4:0] = 5'h1F; bus.wb_data_i[15:0] = 16'h1357;
      bus.wb_addr_i[9:5] = 5'h1E; bus.wb_data_i[31:16] = 16'h2468;
      tick(); idle(); #1;
      checks++; if (bus.prim_op_o[15:0] !== 16'h001F) begin errors++; $display("FAIL lit_prim: got %h want 001f", bus.prim_op_o[15:0]); end
      checks++; if (bus.sec_op_o[15:0] !== 16'hC0DE || bus.lane_en_o !== 2'b01) begin errors++; $display("FAIL lit_sec: got %h/%b want c0de/01", bus.sec_op_o[15:0], bus.lane_en_o); end
      tick();
   endtask

`ifdef RRS_SCOREBOARD_EN
   task automatic test_scoreboard();
      idle(); bus.in_valid_i = 1; bus.lane_en_i = 2'b01; bus.pwrite_i = 2'b01; bus.prim_addr_i[4:0] = 5'd4;
      tick();
      idle(); bus.in_valid_i = 1; bus.lane_en_i = 2'b01; bus.pread_i = 2'b01; bus.prim_addr_i[4:0] = 5'd4;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL sb_stall[%0d]: got %b want 0", i, bus.in_ready_o); end
         tick();
      end
      bus.wb_en_i = 4'b1000; bus.wb_addr_i[19:15] = 5'd4; bus.wb_data_i[63:48] = 16'h4444; #1;
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL sb_release: got %b want 1", bus.in_ready_o); end
      tick(); idle(); tick(); #1;
      checks++; if (bus.out_valid_o !== 1'b1 || bus.prim_op_o[15:0] !== 16'h4444) begin errors++; $display("FAIL sb_value: got %b/%h want 1/4444", bus.out_valid_o, bus.prim_op_o[15:0]); end
      tick();
   endtask
`endif

   task automatic test_random();
      logic [15:0] sf;
      logic        ov;
      bundle_t     b;
      for (int n = 0; n < 400; n++) begin
         bus.in_valid_i  = ($urandom_range(0, 9) < 7);
         bus.lane_en_i   = 2'($urandom());
         bus.pwrite_i    = 2'($urandom()) & 2'($urandom());
         bus.pread_i     = 2'($urandom());
         bus.sread_i     = 2'($urandom());
         bus.opcode_i    = 14'($urandom());
         bus.func_type_i = 4'($urandom());
         for (int l = 0; l < LANES; l++) begin
            bus.prim_addr_i[l*5 +: 5] = 5'($urandom_range(0, 7));
            sf = 16'($urandom()); sf[4:3] = 2'b00;
            bus.sec_field_i[l*16 +: 16] = sf;
         end
         bus.wb_en_i = 4'($urandom());
         for (int p = 0; p < WB_PORTS; p++) begin
            bus.wb_addr_i[p*5 +: 5]  = 5'($urandom_range(0, 7));
            bus.wb_data_i[p*16 +: 16] = 16'($urandom());
         end
         bus.out_ready_i = ($urandom_range(0, 9) < 7);
         bus.flush_i     = ($urandom_range(0, 19) == 0);
         #1;
         checks++; if (bus.in_ready_o !== m_rdy()) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, bus.in_ready_o, m_rdy()); end
         ov = m_ov();
         checks++; if (bus.out_valid_o !== ov) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, bus.out_valid_o, ov); end
         if (ov) begin
            b = q[0];
            checks++; if (bus.lane_en_o !== b.lane_en || (bus.wb_o & b.lane_en) !== (b.pwrite & b.lane_en)) begin errors++; $display("FAIL rnd_lane@%0d: got %b/%b want %b/%b", n, bus.lane_en_o, bus.wb_o, b.lane_en, b.pwrite); end
            for (int l = 0; l < LANES; l++) begin
               if (b.lane_en[l]) begin
                  checks++; if (bus.opcode_o[l*7 +: 7] !== b.opc[l*7 +: 7] || bus.func_type_o[l*2 +: 2] !== b.ft[l*2 +: 2] || bus.reg_addr_o[l*5 +: 5] !== b.paddr[l*5 +: 5]) begin errors++; $display("FAIL rnd_fields@%0d lane%0d: got %h/%h/%h want %h/%h/%h", n, l, bus.opcode_o[l*7 +: 7], bus.func_type_o[l*2 +: 2], bus.reg_addr_o[l*5 +: 5], b.opc[l*7 +: 7], b.ft[l*2 +: 2], b.paddr[l*5 +: 5]); end
                  checks++; if (bus.prim_op_o[l*16 +: 16] !== m_prim(b, l)) begin errors++; $display("FAIL rnd_prim@%0d lane%0d: got %h want %h", n, l, bus.prim_op_o[l*16 +: 16], m_prim(b, l)); end
                  checks++; if (bus.sec_op_o[l*16 +: 16] !== m_sec(b, l)) begin errors++; $display("FAIL rnd_sec@%0d lane%0d: got %h want %h", n, l, bus.sec_op_o[l*16 +: 16], m_sec(b, l)); end
               end
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_forward();
      test_backpressure();
      test_flush();
      test_literal();
`ifdef RRS_SCOREBOARD_EN
      test_scoreboard();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
